// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for the game display.
// It divides CLK down to the pixel rate and runs the horizontal and vertical
// counters. It presents ADDRH/ADDRV to the colour stage, samples the returned
// COLOUR, and drives registered HS, VS and COLOUR_OUT. HS, VS and COLOUR_OUT
// lag the counters by one pixel. FRAME_START marks each wrap to (0,0).
module vga_timing_gen #(
   parameter int   CLK_DIV     = 4,
   parameter int   H_VISIBLE   = 640,
   parameter int   H_FRONT     = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BACK      = 48,
   parameter int   V_VISIBLE   = 480,
   parameter int   V_FRONT     = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BACK      = 33,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] COLOUR,
   output logic [9:0] ADDRH,
   output logic [8:0] ADDRV,
   output logic       HS,
   output logic       VS,
   output logic [7:0] COLOUR_OUT,
   output logic       PIXEL_TICK,
   output logic       FRAME_START
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

   localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
   localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [DIV_W-1:0] divider;
   logic [9:0]       hcount;
   logic [9:0]       vcount;
   logic [9:0]       hcount_next;
   logic [9:0]       vcount_next;
   logic             h_wrap;
   logic             v_wrap;
   logic             visible;
   logic             visible_next;
   logic             hs_active;
   logic             vs_active;

   // Next raster position, plus the visibility and sync decodes for both the current and next pixel
   always_comb begin
      h_wrap       = (hcount == H_LAST);
      v_wrap       = (vcount == V_LAST);
      hcount_next  = h_wrap ? 10'd0 : hcount + 10'd1;
      vcount_next  = vcount;
      if (h_wrap) begin
         vcount_next = v_wrap ? 10'd0 : vcount + 10'd1;
      end
      visible      = (hcount < H_VIS) && (vcount < V_VIS);
      visible_next = (hcount_next < H_VIS) && (vcount_next < V_VIS);
      hs_active    = (hcount >= H_SYNC_START) && (hcount < H_SYNC_END);
      vs_active    = (vcount >= V_SYNC_START) && (vcount < V_SYNC_END);
   end

   // Pixel-rate divider; the tick is registered so it is high exactly while divider is at its last value
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         divider    <= '0;
         PIXEL_TICK <= 1'b0;
      end else begin
         divider    <= (divider == DIV_LAST) ? '0 : divider + 1'b1;
         PIXEL_TICK <= (divider == DIV_PRE);
      end
   end

   // Raster counters and the addresses handed to the colour stage, which always track the counters
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         hcount <= '0;
         vcount <= '0;
         ADDRH  <= '0;
         ADDRV  <= '0;
      end else if (PIXEL_TICK) begin
         hcount <= hcount_next;
         vcount <= vcount_next;
         ADDRH  <= visible_next ? hcount_next : 10'd0;
         ADDRV  <= visible_next ? vcount_next[8:0] : 9'd0;
      end
   end

   // VGA pins take the pixel that is just ending, so colour and both syncs stay aligned one pixel behind the counters
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         COLOUR_OUT <= '0;
         HS         <= ~SYNC_ACTIVE;
         VS         <= ~SYNC_ACTIVE;
      end else if (PIXEL_TICK) begin
         COLOUR_OUT <= visible ? COLOUR : 8'd0;
         HS         <= hs_active ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         VS         <= vs_active ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      end
   end

   // One-CLK strobe on the cycle the counters land on (0,0); the state after reset does not count as a wrap
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         FRAME_START <= 1'b0;
      end else begin
         FRAME_START <= PIXEL_TICK && h_wrap && v_wrap;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// A shrunken-timing instance runs several whole frames and takes a mid-sync
// reset. A default-timing instance runs a little over two lines so the real
// HS figures are exercised. Expected values come from the bench's own
// edge count since reset release.
module tb_vga_timing_gen;

   // Shrunken raster: 15 pixels x 12 lines, 2 CLKs per pixel, 360 CLKs per frame
   localparam int S_DIV   = 2;
   localparam int S_HV    = 8;
   localparam int S_HF    = 2;
   localparam int S_HSY   = 3;
   localparam int S_HB    = 2;
   localparam int S_VV    = 6;
   localparam int S_VF    = 2;
   localparam int S_VSY   = 2;
   localparam int S_VB    = 2;
   localparam int S_HT    = S_HV + S_HF + S_HSY + S_HB;
   localparam int S_VT    = S_VV + S_VF + S_VSY + S_VB;
   localparam int S_FPIX  = S_HT * S_VT;
   localparam int S_FRAME = S_FPIX * S_DIV;

   // Default 640x480 raster
   localparam int B_DIV = 4;
   localparam int B_HT  = 800;
   localparam int B_VT  = 525;

   logic       clk;
   logic       rst_s_n;
   logic       rst_b_n;
   logic [7:0] colour_s;
   logic [7:0] colour_b;

   logic [9:0] addrh_s, addrh_b;
   logic [8:0] addrv_s, addrv_b;
   logic       hs_s, hs_b, vs_s, vs_b;
   logic [7:0] colour_out_s, colour_out_b;
   logic       tick_s, tick_b, fs_s, fs_b;

   int         errors;
   int         checks;
   int         t_s;
   int         t_b;
   bit         s_in_reset;
   logic [7:0] exp_q[$];
   logic [7:0] last_colour_exp;
   int         fs_seen;
   int         last_fs_t;
   logic       hs_prev_b;
   int         hs_fall_t;
   int         hs_fall_count;

   vga_timing_gen #(
      .CLK_DIV(S_DIV), .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HSY), .H_BACK(S_HB),
      .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VSY), .V_BACK(S_VB), .SYNC_ACTIVE(1'b0)
   ) dut_small (
      .CLK(clk), .RESET(rst_s_n), .COLOUR(colour_s),
      .ADDRH(addrh_s), .ADDRV(addrv_s), .HS(hs_s), .VS(vs_s),
      .COLOUR_OUT(colour_out_s), .PIXEL_TICK(tick_s), .FRAME_START(fs_s)
   );

   vga_timing_gen dut_big (
      .CLK(clk), .RESET(rst_b_n), .COLOUR(colour_b),
      .ADDRH(addrh_b), .ADDRV(addrv_b), .HS(hs_b), .VS(vs_b),
      .COLOUR_OUT(colour_out_b), .PIXEL_TICK(tick_b), .FRAME_START(fs_b)
   );

   // 10 ns system clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit in_range(input int x, input int lo, input int len);
      return (x >= lo) && (x < lo + len);
   endfunction

   task automatic check_reset_small(input string pfx);
      check({pfx, "_hs"}, 32'(hs_s), 32'd1);
      check({pfx, "_vs"}, 32'(vs_s), 32'd1);
      check({pfx, "_addrh"}, 32'(addrh_s), 32'd0);
      check({pfx, "_addrv"}, 32'(addrv_s), 32'd0);
      check({pfx, "_colour_out"}, 32'(colour_out_s), 32'd0);
      check({pfx, "_tick"}, 32'(tick_s), 32'd0);
      check({pfx, "_frame_start"}, 32'(fs_s), 32'd0);
   endtask

   // Chooses the colour for pixel p of the small raster and records what COLOUR_OUT must show one pixel later
   task automatic drive_small(input int p);
      int         h;
      int         v;
      bit         vis;
      logic [7:0] c;
      h   = p % S_HT;
      v   = (p / S_HT) % S_VT;
      vis = (h < S_HV) && (v < S_VV);
      c   = 8'($urandom);
      if (vis) begin
         case ((p / S_FPIX) % 3)
            0:       c = 8'hFF;
            1:       c = 8'(h);
            default: c = 8'($urandom);
         endcase
      end
      colour_s = c;
      exp_q.push_back(vis ? c : 8'h00);
   endtask

   task automatic check_small();
      int p;
      int ph;
      int h;
      int v;
      int q;
      bit vis;
      p   = t_s / S_DIV;
      ph  = t_s % S_DIV;
      h   = p % S_HT;
      v   = (p / S_HT) % S_VT;
      vis = (h < S_HV) && (v < S_VV);
      check("s_tick", 32'(tick_s), 32'(ph == S_DIV - 1));
      check("s_addrh", 32'(addrh_s), vis ? h : 0);
      check("s_addrv", 32'(addrv_s), vis ? v : 0);
      check("s_frame_start", 32'(fs_s), 32'(ph == 0 && p > 0 && (p % S_FPIX) == 0));
      if (p == 0) begin
         check("s_hs", 32'(hs_s), 32'd1);
         check("s_vs", 32'(vs_s), 32'd1);
         check("s_colour_out", 32'(colour_out_s), 32'd0);
      end else begin
         q = p - 1;
         check("s_hs", 32'(hs_s), 32'(!in_range(q % S_HT, S_HV + S_HF, S_HSY)));
         check("s_vs", 32'(vs_s), 32'(!in_range((q / S_HT) % S_VT, S_VV + S_VF, S_VSY)));
         if (ph == 0) begin
            if (exp_q.size() > 0) begin
               last_colour_exp = exp_q.pop_front();
            end else begin
               last_colour_exp = 8'h00;
            end
         end
         check("s_colour_out", 32'(colour_out_s), 32'(last_colour_exp));
      end
      if (fs_s === 1'b1) begin
         if (fs_seen > 0) check("s_frame_spacing", t_s - last_fs_t, S_FRAME);
         last_fs_t = t_s;
         fs_seen++;
      end
      if (ph == 0) drive_small(p);
   endtask

   task automatic check_big();
      int p;
      int ph;
      int h;
      int v;
      int q;
      bit vis;
      p   = t_b / B_DIV;
      ph  = t_b % B_DIV;
      h   = p % B_HT;
      v   = (p / B_HT) % B_VT;
      vis = (h < 640) && (v < 480);
      check("b_tick", 32'(tick_b), 32'(ph == B_DIV - 1));
      check("b_addrh", 32'(addrh_b), vis ? h : 0);
      check("b_addrv", 32'(addrv_b), vis ? v : 0);
      check("b_frame_start", 32'(fs_b), 32'd0);
      if (p == 0) begin
         check("b_hs", 32'(hs_b), 32'd1);
         check("b_vs", 32'(vs_b), 32'd1);
         check("b_colour_out", 32'(colour_out_b), 32'd0);
      end else begin
         q = p - 1;
         check("b_hs", 32'(hs_b), 32'(!in_range(q % B_HT, 656, 96)));
         check("b_vs", 32'(vs_b), 32'(!in_range((q / B_HT) % B_VT, 490, 2)));
         check("b_colour_out", 32'(colour_out_b),
               32'(((q % B_HT) < 640 && ((q / B_HT) % B_VT) < 480) ? 8'hFF : 8'h00));
      end
      if (hs_b !== hs_prev_b) begin
         if (hs_b === 1'b0) begin
            if (hs_fall_count == 0) check("b_hs_first_fall", t_b, 2628);
            else check("b_hs_period", t_b - hs_fall_t, 3200);
            hs_fall_t = t_b;
            hs_fall_count++;
         end else begin
            check("b_hs_width", t_b - hs_fall_t, 384);
         end
         hs_prev_b = hs_b;
      end
   endtask

   // Advances one CLK and checks both instances #1 after the edge
   task automatic step();
      @(posedge clk);
      #1;
      t_b++;
      check_big();
      if (s_in_reset) begin
         check_reset_small("s_rst_hold");
      end else begin
         t_s++;
         check_small();
      end
   endtask

   task automatic restart_small();
      t_s             = 0;
      fs_seen         = 0;
      last_fs_t       = 0;
      last_colour_exp = 8'h00;
      exp_q.delete();
      check_small();
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      t_s           = 0;
      t_b           = 0;
      s_in_reset    = 1'b1;
      hs_prev_b     = 1'b1;
      hs_fall_t     = 0;
      hs_fall_count = 0;
      rst_s_n       = 1'b0;
      rst_b_n       = 1'b0;
      colour_s      = 8'h5A;
      colour_b      = 8'hFF;

      // Hold reset over several edges, then release both instances together
      repeat (3) @(posedge clk);
      #1;
      check_reset_small("s_reset");
      check("b_reset_hs", 32'(hs_b), 32'd1);
      check("b_reset_colour_out", 32'(colour_out_b), 32'd0);
      @(negedge clk);
      rst_s_n    = 1'b1;
      rst_b_n    = 1'b1;
      s_in_reset = 1'b0;
      check_big();
      restart_small();

      // Free-run the small raster until it sits inside both sync pulses
      while (!(t_s > 2 * S_FRAME &&
               (t_s / S_DIV) % S_HT == S_HV + S_HF + 1 &&
               ((t_s / S_DIV) / S_HT) % S_VT == S_VV + S_VF &&
               (t_s % S_DIV) == 1) && t_b < 6000) begin
         step();
      end
      check("s_mid_sync_hs", 32'(hs_s), 32'd0);
      check("s_mid_sync_vs", 32'(vs_s), 32'd0);

      // Asynchronous reset in the middle of a CLK: outputs must drop before any edge
      #2;
      rst_s_n    = 1'b0;
      s_in_reset = 1'b1;
      #1;
      check_reset_small("s_async");
      step();
      step();
      @(negedge clk);
      rst_s_n    = 1'b1;
      s_in_reset = 1'b0;
      restart_small();

      // Keep both running past the second HS pulse of the default raster
      while (t_b < 6600) step();

      check("b_hs_fall_count", hs_fall_count, 2);
      check("s_frame_count", fs_seen, t_s / S_FRAME);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing stage for the game display. It generates the 640x480@60 Hz pixel/line counters that drive ADDRH/ADDRV into the snake/apple colour logic, samples the returned COLOUR, and drives the registered VGA pins (HS, VS, COLOUR_OUT). It also emits a once-per-frame strobe for the game-tick divider.

Parameters:
CLK_DIV, 4, CLK cycles per pixel (100 MHz CLK -> 25 MHz pixel); legal values >= 2
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of HS/VS

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-low reset
COLOUR  input  8  pixel colour from the colour stage for the current ADDRH/ADDRV
ADDRH  output  10  horizontal pixel address; 0 outside the visible area
ADDRV  output  9  vertical line address; 0 outside the visible area
HS  output  1  horizontal sync
VS  output  1  vertical sync
COLOUR_OUT  output  8  registered RGB to the DAC; 0 during blanking
PIXEL_TICK  output  1  one-CLK strobe at the end of every pixel period
FRAME_START  output  1  one-CLK strobe when the counters wrap to (0,0)

Behaviour:
- Derived totals: H_TOTAL = 800, V_TOTAL = 525 at defaults.
- Divider counter runs 0..CLK_DIV-1. PIXEL_TICK is high for exactly the CLK cycle where divider == CLK_DIV-1.
- hcount (10b) increments on PIXEL_TICK and wraps at H_TOTAL-1 -> 0.
- vcount (10b) increments only when hcount wraps, and wraps at V_TOTAL-1 -> 0.
- ADDRH = hcount when hcount < H_VISIBLE && vcount < V_VISIBLE, else 0. ADDRV follows the same rule using vcount[8:0]. Both are registered and change only on the CLK after PIXEL_TICK.
- ADDRH/ADDRV are stable for CLK_DIV cycles, so the colour stage may register COLOUR one CLK after an address change.
- On each PIXEL_TICK, using the pre-increment counters:
  - COLOUR_OUT <= visible ? COLOUR : 0.
  - HS <= SYNC_ACTIVE if H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC (656..751), else !SYNC_ACTIVE.
  - VS <= SYNC_ACTIVE if 490 <= vcount <= 491, else !SYNC_ACTIVE.
  - Net effect: pins lag the counters by one pixel and stay mutually aligned.
- FRAME_START pulses for one CLK on the cycle the counters become (0,0). It never pulses out of reset; the first pulse comes after a full frame.
- Reset (asynchronous, RESET low):
  - Divider, hcount, vcount, ADDRH, ADDRV, COLOUR_OUT, PIXEL_TICK and FRAME_START all go to 0.
  - HS and VS go to !SYNC_ACTIVE.
  - Release starts the divider at 0; the first PIXEL_TICK occurs CLK_DIV cycles after release.
- Reset asserted mid-line or mid-frame drops all outputs at once. No partial sync pulse may be extended.
- COLOUR is ignored outside the visible area, including X/garbage values.

Test Plan:
- Reset hold, then release -> HS=VS=1, COLOUR_OUT=0, ADDRH=ADDRV=0; first PIXEL_TICK at CLK 4, then every 4 CLKs.
- Free-run one line -> HS low for exactly 384 CLKs, starting 657 pixel ticks (2628 CLKs) after line start; HS period 3200 CLKs.
- Free-run two frames -> VS low for 2 lines (6400 CLKs) per frame; FRAME_START spacing exactly 1,680,000 CLKs, one CLK wide.
- COLOUR tied to 8'hFF -> COLOUR_OUT=FF for 640 pixels per line on lines 0..479, and 0 elsewhere; ADDRH sweeps 0..639, ADDRV sweeps 0..479.
- COLOUR driven as ADDRH[7:0] -> COLOUR_OUT shows the same value one pixel later (no skew vs HS).
- RESET pulsed low at hcount=700, vcount=490 -> HS/VS return to 1 within the reset assertion; after release the counters restart from (0,0) and no FRAME_START occurs until a full frame has elapsed.
